// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer signal bundle: the key-press input from the debouncer and the
// buzzer/LED enables plus status outputs that go to the downstream blocks.
interface alarm_sequencer_if #(
   parameter int MAX_SNOOZE = 3
);
   localparam int SNZ_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

   logic             key_press;   // one-cycle press pulse, every high cycle is an event
   logic             beep_en;     // buzzer enable
   logic             led_en;      // breathing-LED enable
   logic [1:0]       state;       // 0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZE
   logic [SNZ_W-1:0] snooze_cnt;  // snoozes used in the current alarm cycle
   logic             missed;      // one-cycle pulse when ringing times out

   // Side that produces key presses and watches the alarm status
   modport master (
      output key_press,
      input  beep_en, led_en, state, snooze_cnt, missed
   );

   // The sequencer itself
   modport slave (
      input  key_press,
      output beep_en, led_en, state, snooze_cnt, missed
   );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: turns debounced key presses into a timed
// arm -> ring -> snooze/dismiss cycle. A prescaler produces a tick every
// TICK_DIV clocks and a shared tick counter times the residency of each state.
// beep_en and led_en are decoded from the state register only.
module alarm_sequencer #(
   parameter int TICK_DIV     = 50000,
   parameter int ARM_TICKS    = 5000,
   parameter int RING_TICKS   = 30000,
   parameter int SNOOZE_TICKS = 10000,
   parameter int MAX_SNOOZE   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   alarm_sequencer_if.slave   bus
);

   // ------------------------------------------------------------------------
   // Widths and constants
   // ------------------------------------------------------------------------
   localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MAX_LIM = (ARM_TICKS > RING_TICKS)
                            ? ((ARM_TICKS > SNOOZE_TICKS) ? ARM_TICKS : SNOOZE_TICKS)
                            : ((RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS);
   localparam int CNT_W   = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;
   localparam int SNZ_W   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

   localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_TICKS - 1);
   localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TICKS - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_TICKS - 1);
   localparam logic [SNZ_W-1:0] SNZ_MAX     = SNZ_W'(MAX_SNOOZE);

   // The encoding is dense (all four codes are real states), so there is no
   // illegal state to recover from.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2,
      ST_SNOOZE  = 2'd3
   } state_e;

   // ------------------------------------------------------------------------
   // Registers and next-state signals
   // ------------------------------------------------------------------------
   state_e           state_q,    state_d;
   logic [PRE_W-1:0] presc_q,    presc_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [SNZ_W-1:0] snooze_q,   snooze_d;
   logic             missed_q,   missed_d;

   logic             tick;        // prescaler at its last count this cycle
   logic [CNT_W-1:0] limit_last;  // tick count at which the current state expires
   logic             expired;     // current state's timer fires this cycle
   logic             enter;       // a transition (into any state) happens this edge

   // Tick generation and expiry detection for the current state
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves
      // it unassigned; a missing default would infer a latch.
      limit_last = '0;
      tick       = (presc_q == PRE_LAST);
      unique case (state_q)
         ST_ARMED:   limit_last = ARM_LAST;
         ST_RINGING: limit_last = RING_LAST;
         ST_SNOOZE:  limit_last = SNOOZE_LAST;
         default:    limit_last = '0;
      endcase
      expired = (state_q != ST_IDLE) && tick && (tick_cnt_q == limit_last);
   end

   // Next-state logic; a press wins over a timer expiry in the same cycle
   always_comb begin
      state_d  = state_q;
      snooze_d = snooze_q;
      missed_d = 1'b0;
      enter    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.key_press) begin
               state_d = ST_ARMED;
               enter   = 1'b1;
            end
         end

         ST_ARMED: begin
            if (bus.key_press) begin
               state_d = ST_IDLE;        // cancel before ringing
               enter   = 1'b1;
            end else if (expired) begin
               state_d = ST_RINGING;
               enter   = 1'b1;
            end
         end

         ST_RINGING: begin
            if (bus.key_press) begin
               enter = 1'b1;
               if (snooze_q < SNZ_MAX) begin
                  state_d  = ST_SNOOZE;
                  snooze_d = snooze_q + SNZ_W'(1);
               end else begin
                  state_d  = ST_IDLE;    // snooze budget spent: dismiss
               end
            end else if (expired) begin
               state_d  = ST_IDLE;       // nobody answered
               missed_d = 1'b1;
               enter    = 1'b1;
            end
         end

         ST_SNOOZE: begin
            if (bus.key_press) begin
               state_d = ST_IDLE;        // dismiss during snooze
               enter   = 1'b1;
            end else if (expired) begin
               state_d = ST_RINGING;
               enter   = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            enter   = 1'b1;
         end
      endcase

      // A fresh alarm cycle starts with the full snooze budget.
      if (state_d == ST_IDLE) begin
         snooze_d = '0;
      end
   end

   // Prescaler and tick counter: restart on every transition, frozen in IDLE
   always_comb begin
      presc_d    = presc_q;
      tick_cnt_d = tick_cnt_q;
      if (enter || (state_q == ST_IDLE)) begin
         presc_d    = '0;
         tick_cnt_d = '0;
      end else if (tick) begin
         presc_d    = '0;
         tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end else begin
         presc_d    = presc_q + PRE_W'(1);
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         tick_cnt_q <= '0;
         snooze_q   <= '0;
         missed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         tick_cnt_q <= tick_cnt_d;
         snooze_q   <= snooze_d;
         missed_q   <= missed_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from registers only, so reset drops them immediately
   // ------------------------------------------------------------------------
   assign bus.beep_en    = (state_q == ST_RINGING);
   assign bus.led_en     = (state_q != ST_IDLE);
   assign bus.state      = state_q;
   assign bus.snooze_cnt = snooze_q;
   assign bus.missed     = missed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer. A driver issues one key_press decision per cycle
// (at the falling edge), steps a cycle-countdown reference model and queues the
// expected post-edge outputs; a monitor pops and compares one entry after each
// rising edge. Directed scenarios cover the timing corners, then random presses.
module tb_alarm_sequencer;

   localparam int TICK_DIV     = 4;
   localparam int ARM_TICKS    = 3;
   localparam int RING_TICKS   = 5;
   localparam int SNOOZE_TICKS = 2;
   localparam int MAX_SNOOZE   = 2;

   typedef struct packed {
      logic [1:0] state;
      logic       beep;
      logic       led;
      logic [1:0] snz;
      logic       missed;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;

   alarm_sequencer_if #(.MAX_SNOOZE(MAX_SNOOZE)) bus ();

   alarm_sequencer #(
      .TICK_DIV     (TICK_DIV),
      .ARM_TICKS    (ARM_TICKS),
      .RING_TICKS   (RING_TICKS),
      .SNOOZE_TICKS (SNOOZE_TICKS),
      .MAX_SNOOZE   (MAX_SNOOZE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   obs_t sb[$];

   // Reference model: state plus remaining cycles until the state times out.
   int   m_state;   // 0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZE
   int   m_rem;
   int   m_snz;
   bit   m_missed;

   obs_t obs_now;          // DUT outputs seen at the most recent driver step
   int   missed_seen = 0;  // missed pulses observed by the driver

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int limit_of(input int s);
      case (s)
         1:       return ARM_TICKS * TICK_DIV;
         2:       return RING_TICKS * TICK_DIV;
         3:       return SNOOZE_TICKS * TICK_DIV;
         default: return 0;
      endcase
   endfunction

   task automatic model_enter(input int s);
      m_state = s;
      m_rem   = limit_of(s);
      if (s == 0) m_snz = 0;
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_rem    = 0;
      m_snz    = 0;
      m_missed = 1'b0;
   endtask

   // One clock of behaviour: press first, otherwise count down the residency.
   task automatic model_step(input bit press);
      m_missed = 1'b0;
      case (m_state)
         0: if (press) model_enter(1);
         1: begin
            if (press)           model_enter(0);
            else if (m_rem == 1) model_enter(2);
            else                 m_rem--;
         end
         2: begin
            if (press) begin
               if (m_snz < MAX_SNOOZE) begin
                  m_snz++;
                  model_enter(3);
               end else begin
                  model_enter(0);
               end
            end else if (m_rem == 1) begin
               model_enter(0);
               m_missed = 1'b1;
            end else begin
               m_rem--;
            end
         end
         default: begin
            if (press)           model_enter(0);
            else if (m_rem == 1) model_enter(2);
            else                 m_rem--;
         end
      endcase
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.state  = 2'(m_state);
      o.beep   = (m_state == 2);
      o.led    = (m_state != 0);
      o.snz    = 2'(m_snz);
      o.missed = m_missed;
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.state  = bus.state;
      o.beep   = bus.beep_en;
      o.led    = bus.led_en;
      o.snz    = bus.snooze_cnt;
      o.missed = bus.missed;
      return o;
   endfunction

   // Driver: decide the press for the coming rising edge and queue the result.
   task automatic step(input bit press);
      @(negedge clk);
      obs_now = dut_obs();
      if (obs_now.missed) missed_seen++;
      bus.key_press = press;
      model_step(press);
      sb.push_back(model_obs());
   endtask

   // Idle until the model reaches state s (and remaining count rem, if nonzero).
   task automatic advance_until(input int s, input int rem);
      int guard = 0;
      while (!(m_state == s && (rem == 0 || m_rem == rem))) begin
         step(1'b0);
         guard++;
         if (guard > 200) begin
            check("advance_timeout", 32'(m_state), 32'(s));
            break;
         end
      end
   endtask

   // Count consecutive observed cycles in state s without pressing.
   task automatic count_state(input int s, output int n);
      n = (obs_now.state == 2'(s)) ? 1 : 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b0);
         if (obs_now.state == 2'(s)) n++;
         else if (n > 0) break;
      end
   endtask

   // Asynchronous reset dropped between clock edges.
   task automatic async_reset();
      @(negedge clk);
      bus.key_press = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_state", 32'(bus.state),   32'd0);
      check("async_rst_beep",  32'(bus.beep_en), 32'd0);
      check("async_rst_led",   32'(bus.led_en),  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Monitor: compare one queued expectation after each rising edge.
   initial begin
      obs_t exp_o;
      obs_t got_o;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            exp_o = sb.pop_front();
            got_o = dut_obs();
            check("scoreboard", 32'(got_o), 32'(exp_o));
         end
      end
   end

   // Global time limit so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int m0;

      rst_n         = 1'b0;
      bus.key_press = 1'b0;
      model_reset();
      #1;
      check("reset_state", 32'(bus.state),      32'd0);
      check("reset_beep",  32'(bus.beep_en),    32'd0);
      check("reset_led",   32'(bus.led_en),     32'd0);
      check("reset_snz",   32'(bus.snooze_cnt), 32'd0);
      check("reset_miss",  32'(bus.missed),     32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Quiet idle period: nothing must move.
      repeat (100) step(1'b0);
      check("idle_missed", 32'(missed_seen), 32'd0);

      // Full arm -> ring -> timeout cycle.
      step(1'b1);
      count_state(1, n);
      check("arm_residency", 32'(n), 32'd12);
      m0 = missed_seen;
      count_state(2, n);
      check("ring_residency", 32'(n), 32'd20);
      repeat (3) step(1'b0);
      check("ring_timeout_missed", 32'(missed_seen - m0), 32'd1);
      check("ring_timeout_snz", 32'(obs_now.snz), 32'd0);

      // Snooze twice, then the third press dismisses.
      step(1'b1);
      advance_until(2, 0);
      step(1'b1);
      count_state(3, n);
      check("snooze_residency", 32'(n), 32'd8);
      step(1'b1);
      advance_until(2, 0);
      step(1'b1);
      step(1'b0);
      check("third_press_state", 32'(obs_now.state), 32'd0);
      check("third_press_snz",   32'(obs_now.snz),   32'd0);

      // Press on the same cycle ARMED expires: cancel wins.
      step(1'b1);
      advance_until(1, 1);
      step(1'b1);
      step(1'b0);
      check("arm_collision", 32'(obs_now.state), 32'd0);

      // Press during SNOOZE dismisses at once.
      step(1'b1);
      advance_until(2, 0);
      step(1'b1);
      step(1'b0);
      step(1'b1);
      step(1'b0);
      check("snooze_dismiss", 32'(obs_now.state), 32'd0);

      // Press on the same cycle RINGING expires: snooze wins, no missed pulse.
      step(1'b1);
      advance_until(2, 0);
      m0 = missed_seen;
      advance_until(2, 1);
      step(1'b1);
      step(1'b0);
      check("ring_collision", 32'(obs_now.state), 32'd3);
      check("ring_collision_missed", 32'(missed_seen - m0), 32'd0);
      step(1'b1);

      // Back-to-back presses: IDLE -> ARMED -> IDLE.
      step(1'b1);
      step(1'b1);
      step(1'b0);
      check("back_to_back", 32'(obs_now.state), 32'd0);

      // Asynchronous reset while ringing, then a clean full arm period.
      step(1'b1);
      advance_until(2, 0);
      repeat (5) step(1'b0);
      check("pre_reset_beep", 32'(bus.beep_en), 32'd1);
      async_reset();
      step(1'b1);
      count_state(1, n);
      check("arm_after_reset", 32'(n), 32'd12);
      step(1'b1);

      // Random presses, with an occasional asynchronous reset.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) async_reset();
         step($urandom_range(0, 9) == 0);
      end

      @(negedge clk);
      bus.key_press = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("scoreboard_drain", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
